// File: rtl/dec_round_key_store_pkg.sv
// Shared constants and types for the decryption round-key store.
// Round index width, key width, storage depth and FSM state encoding.
package dec_round_key_store_pkg;

    localparam int NUM_ROUNDS   = 10;
    localparam int ROUND_W      = 4;
    localparam int BLOCK_LENGTH = 128;
    localparam int DEPTH        = NUM_ROUNDS + 1;

    typedef logic [ROUND_W-1:0]      round_t;
    typedef logic [BLOCK_LENGTH-1:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DRAIN,
        READY
    } kst_e;

    function automatic logic in_range(round_t r);
        return r <= round_t'(NUM_ROUNDS);
    endfunction

endpackage

// File: rtl/dec_round_key_store_if.sv
// Round-key read bus between the decryption datapath (master) and the store (slave).
// rd_en/rd_round request a key; rd_valid/rd_key return it one cycle later.
interface dec_round_key_store_if;
    import dec_round_key_store_pkg::*;

    logic   rd_en;
    round_t rd_round;
    logic   rd_valid;
    rkey_t  rd_key;

    modport master (
        output rd_en,
        output rd_round,
        input  rd_valid,
        input  rd_key
    );

    modport slave (
        input  rd_en,
        input  rd_round,
        output rd_valid,
        output rd_key
    );

endinterface

// File: rtl/dec_round_key_store_ram.sv
// Round-key storage: DEPTH x BLOCK_LENGTH, one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (read, rdata holds when re=0).
module dec_round_key_store_ram
    import dec_round_key_store_pkg::*;
(
    input  logic   clk,
    input  logic   we,
    input  round_t waddr,
    input  rkey_t  wdata,
    input  logic   re,
    input  round_t raddr,
    output rkey_t  rdata
);

    rkey_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dec_round_key_store.sv
// Steps the key generator through rounds 0..NUM_ROUNDS, stores the round keys and
// serves them by index. Ports: clk, rst (sync, active-low), key_load, gen_en,
// gen_round, gen_key, busy, keys_ready, rd (read bus slave).
module dec_round_key_store
    import dec_round_key_store_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   key_load,
    output logic   gen_en,
    output round_t gen_round,
    input  rkey_t  gen_key,
    output logic   busy,
    output logic   keys_ready,
    dec_round_key_store_if.slave rd
);

    localparam round_t LAST = round_t'(NUM_ROUNDS);

    kst_e   state_q;
    kst_e   state_d;
    round_t cnt_q;
    round_t cnt_d;
    logic   rdy_set;
    logic   rdy_clr;

    logic   cap_vld;
    round_t cap_idx;

    logic   rd_acc;
    logic   rd_vld_q;
    logic   rd_zero;
    rkey_t  ram_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gen_en    = 1'b0;
        gen_round = '0;
        busy      = 1'b0;
        rdy_set   = 1'b0;
        rdy_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    state_d = EXPAND;
                    cnt_d   = '0;
                end
            end
            EXPAND: begin
                gen_en    = 1'b1;
                gen_round = cnt_q;
                busy      = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // Last key is still in the capture stage; it lands this edge.
                busy    = 1'b1;
                rdy_set = 1'b1;
                state_d = READY;
            end
            READY: begin
                if (key_load) begin
                    state_d = EXPAND;
                    cnt_d   = '0;
                    rdy_clr = 1'b1;
                end
            end
        endcase
    end

    assign rd_acc = rd.rd_en && keys_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            keys_ready <= 1'b0;
            cap_vld    <= 1'b0;
            cap_idx    <= '0;
            rd_vld_q   <= 1'b0;
            rd_zero    <= 1'b1;
        end else begin
            if (rdy_set) begin
                keys_ready <= 1'b1;
            end else if (rdy_clr) begin
                keys_ready <= 1'b0;
            end
            // Generator output is registered, so capture trails gen_en by one edge.
            cap_vld  <= gen_en;
            cap_idx  <= gen_round;
            rd_vld_q <= rd_acc;
            if (rd_acc) begin
                rd_zero <= !in_range(rd.rd_round);
            end
        end
    end

    dec_round_key_store_ram u_ram (
        .clk   (clk),
        .we    (cap_vld),
        .waddr (cap_idx),
        .wdata (gen_key),
        .re    (rd_acc && in_range(rd.rd_round)),
        .raddr (rd.rd_round),
        .rdata (ram_q)
    );

    // rd_zero covers reset and out-of-range reads, since the RAM itself has no reset.
    assign rd.rd_key   = rd_zero ? '0 : ram_q;
    assign rd.rd_valid = rd_vld_q;

endmodule
